// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped register front end for a byte UART core.
//
// Converts single-beat bus loads/stores into UART register accesses and
// buffers transmit and receive bytes in two FIFOs. Every access is
// acknowledged with a one-cycle Ready pulse on the cycle after it is accepted.
//
// Register map (decoded from address[3:2]):
//   0 TXDATA (W)      push write_data[7:0] into the TX FIFO (dropped if full)
//   1 RXDATA (R)      pop the RX FIFO head, zero-extended (32'h0 if empty)
//   2 STATUS (R/W1C)  [0] tx_full [1] tx_empty [2] rx_empty [3] rx_full
//                     [4] rx_overrun (sticky, write 1 to clear) [8] tx_ie
//   3 BAUD   (R/W)    baud divisor, bits [15:0]
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   address, write_data            bus address / store data
//   MemWrite, MemRead, MemSize     bus request (MemSize is not decoded)
//   data_out, Ready                load data and one-cycle acknowledge
//   tx_data, tx_start, tx_ready    transmit handshake to the UART core
//   rx_data, rx_ready              receive byte and byte-received flag
//   baud_div                       baud divisor to the UART core
//   irq                            interrupt request (only with UART_MMIO_IRQ_EN)
//
// Build option: define UART_MMIO_IRQ_EN to add the irq output and the tx_ie
// enable at STATUS bit 8. Without it, bit 8 reads 0 and ignores writes.

module uart_mmio #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DEFAULT = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  output logic [31:0] data_out,
  output logic        Ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [15:0] baud_div
`ifdef UART_MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic {B_IDLE, B_ACK} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_WAIT, T_DRAIN} tx_state_t;

  bus_state_t  bus_q, bus_d;
  tx_state_t   txs_q, txs_d;
  logic [PW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [31:0] data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] baud_q, baud_d;
  logic        overrun_q, overrun_d;
  logic        rx_prev_q;
  logic        tx_ie_q, tx_ie_d;

  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        access, wr_acc, rd_acc;
  logic [1:0]  reg_sel;
  logic        tx_push, rx_pop, rx_rise, rx_push, ov_set, ov_clr;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{MemSize, address[31:4], address[1:0], write_data[31:16]};

  // Full/empty come from the extra wrap bit: equal pointers mean empty,
  // equal indices with differing wrap bits mean full.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[PW] != tx_rd_q[PW]) && (tx_wr_q[PW-1:0] == tx_rd_q[PW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[PW] != rx_rd_q[PW]) && (rx_wr_q[PW-1:0] == rx_rd_q[PW-1:0]);

  // Writes win over reads when both request lines are high.
  assign access  = (bus_q == B_IDLE) && (MemRead || MemWrite);
  assign wr_acc  = access && MemWrite;
  assign rd_acc  = access && MemRead && !MemWrite;
  assign reg_sel = address[3:2];

  assign tx_push = wr_acc && (reg_sel == 2'd0) && !tx_full;
  assign rx_pop  = rd_acc && (reg_sel == 2'd1) && !rx_empty;
  assign rx_rise = rx_ready && !rx_prev_q;
  // Full is judged on the current count, so a same-cycle pop does not make room.
  assign rx_push = rx_rise && !rx_full;
  assign ov_set  = rx_rise && rx_full;
  assign ov_clr  = wr_acc && (reg_sel == 2'd2) && write_data[4];

  assign status_word = {23'b0, tx_ie_q, 3'b0, overrun_q, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    bus_d      = bus_q;
    ready_d    = 1'b0;
    data_out_d = 32'h0;
    baud_d     = baud_q;
    tx_ie_d    = tx_ie_q;
    tx_wr_d    = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
    rx_rd_d    = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
    rx_wr_d    = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
    // A new overrun in the same cycle as a clear keeps the flag set.
    overrun_d  = ov_set ? 1'b1 : (ov_clr ? 1'b0 : overrun_q);

    case (bus_q)
      B_IDLE: begin
        if (access) begin
          bus_d   = B_ACK;
          ready_d = 1'b1;
        end
      end
      default: bus_d = B_IDLE;
    endcase

    if (wr_acc && (reg_sel == 2'd3)) baud_d = write_data[15:0];
`ifdef UART_MMIO_IRQ_EN
    if (wr_acc && (reg_sel == 2'd2)) tx_ie_d = write_data[8];
`else
    tx_ie_d = 1'b0;
`endif

    if (rd_acc) begin
      case (reg_sel)
        2'd1:    data_out_d = rx_empty ? 32'h0 : {24'b0, rx_mem_q[rx_rd_q[PW-1:0]]};
        2'd2:    data_out_d = status_word;
        2'd3:    data_out_d = {16'b0, baud_q};
        default: data_out_d = 32'h0;
      endcase
    end
  end

  // Transmit drain: launch one byte, then follow the core's busy cycle
  // (tx_ready low, then high again) before looking at the FIFO once more.
  always_comb begin
    txs_d     = txs_q;
    tx_data_d = tx_data_q;
    tx_rd_d   = tx_rd_q;
    case (txs_q)
      T_IDLE: begin
        if (!tx_empty && tx_ready) begin
          txs_d     = T_LAUNCH;
          tx_data_d = tx_mem_q[tx_rd_q[PW-1:0]];
        end
      end
      T_LAUNCH: begin
        tx_rd_d = tx_rd_q + PTR_ONE;
        txs_d   = T_WAIT;
      end
      T_WAIT:  if (!tx_ready) txs_d = T_DRAIN;
      T_DRAIN: if (tx_ready)  txs_d = T_IDLE;
      default: txs_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q      <= B_IDLE;
      txs_q      <= T_IDLE;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      data_out_q <= 32'h0;
      ready_q    <= 1'b0;
      tx_data_q  <= 8'h0;
      baud_q     <= BAUD_DEFAULT;
      overrun_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      tx_ie_q    <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      txs_q      <= txs_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      baud_q     <= baud_d;
      overrun_q  <= overrun_d;
      rx_prev_q  <= rx_ready;
      tx_ie_q    <= tx_ie_d;
    end
  end

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[PW-1:0]] <= write_data[7:0];
    if (rx_push) rx_mem_q[rx_wr_q[PW-1:0]] <= rx_data;
  end

  assign data_out = data_out_q;
  assign Ready    = ready_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (txs_q == T_LAUNCH);
  assign baud_div = baud_q;
`ifdef UART_MMIO_IRQ_EN
  assign irq = !rx_empty || overrun_q || (tx_empty && tx_ie_q);
`endif

endmodule
